ldvio_mp_ram: RTL and testbench
===============================

LDVIO_MP_RAM -- requirements
Module: ldvio_mp_ram

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of entries (need not be a power of two).
REQ-002 SHALL have parameter INDEX, default 4, address width; ceil(log2(DEPTH)) <= INDEX.
REQ-003 SHALL have parameter WIDTH, default 8, entry width.
REQ-004 SHALL have parameter RD_PORTS, default 4, read port count, range 1..8.
REQ-005 SHALL have parameter WR_PORTS, default 2, write port count, range 1..4.
REQ-006 SHALL have parameter BYPASS, default 1, enabling same-cycle write-to-read forwarding.
REQ-007 SHALL have clk  input  1  clock, rising edge.
REQ-008 SHALL have reset  input  1  reset, synchronous, active-high.
REQ-009 SHALL have flush_i  input  1  request to re-clear all entries.
REQ-010 SHALL have rd_addr_i  input  RD_PORTS x INDEX  read addresses.
REQ-011 SHALL have rd_data_o  output  RD_PORTS x WIDTH  read data.
REQ-012 SHALL have wr_addr_i  input  WR_PORTS x INDEX  write addresses.
REQ-013 SHALL have wr_data_i  input  WR_PORTS x WIDTH  write data.
REQ-014 SHALL have we_i  input  WR_PORTS  per-port write enable.
REQ-015 SHALL have ready_o  output  1  storage initialised; writes accepted.

Function
REQ-016 SHALL implement a two-state FSM: CLEAR and READY.
REQ-017 In CLEAR, SHALL zero one entry per cycle at clr_ptr, starting at 0 and incrementing by 1.
REQ-018 SHALL go CLEAR->READY on the cycle after entry DEPTH-1 is zeroed, so CLEAR lasts exactly DEPTH cycles.
REQ-019 In READY, flush_i=1 SHALL move the FSM to CLEAR with clr_ptr=0 next cycle.
REQ-020 In CLEAR, flush_i=1 SHALL restart clr_ptr at 0; the CLEAR period is extended.
REQ-021 ready_o SHALL be 1 exactly when the state is READY.
REQ-022 In CLEAR, SHALL ignore all we_i, and all rd_data_o SHALL be 0.
REQ-023 Reads SHALL be combinational: rd_data_o[p] = entry[rd_addr_i[p]] in the same cycle.
REQ-024 In READY, a write with we_i[w]=1 SHALL update the entry at the next rising edge; it is visible to reads from the next cycle.
REQ-025 Multiple write ports to the same address in one cycle: the highest port index SHALL win.
REQ-026 If BYPASS=1, a read matching an enabled write address SHALL return that cycle's winning write data.
REQ-027 If BYPASS=0, a read matching an enabled write address SHALL return the pre-write value.
REQ-028 A write to address >= DEPTH SHALL be dropped; a read of address >= DEPTH SHALL return 0.
REQ-029 A flush_i in READY SHALL take priority over same-cycle writes; those writes are dropped.

Reset
REQ-030 reset=1 SHALL force state CLEAR and clr_ptr=0 at the next edge, whatever the current state or clr_ptr.
REQ-031 During and after reset, ready_o=0 and rd_data_o=0 until CLEAR completes.
REQ-032 Storage SHALL NOT be bulk-reset in one cycle; clearing SHALL happen only via the CLEAR sequence, so the array maps to RAM.
REQ-033 reset SHALL take priority over flush_i and we_i.

Structure
REQ-034 The shared package SHALL hold the state enum (CLEAR, READY) and the port-count limits (MAX_RD_PORTS=8, MAX_WR_PORTS=4).
REQ-035 Write-port conflict resolution and bypass matching SHALL be one sub-module, ldvio_wr_merge, instantiated once per read port for forwarding.
REQ-036 Port counts SHALL be set by parameters and generate loops, not by per-width conditional compilation.

Verification
REQ-037 Reset, then idle -> ready_o=0 for 16 cycles, then ready_o=1; every address reads 0.
REQ-038 READY; port0 writes addr 3 = 0xA5 and port1 writes addr 3 = 0x5A in the same cycle -> next cycle, addr 3 reads 0x5A on all read ports.
REQ-039 BYPASS=1; write addr 7 = 0x11 while read port 2 addresses 7 -> rd_data_o[2]=0x11 in the same cycle; with BYPASS=0 it reads the old value, 0x00.
REQ-040 READY with entries written; pulse flush_i -> ready_o=0 next cycle, writes ignored for 16 cycles, then all entries read 0.
REQ-041 Assert flush_i at clr_ptr=9 during CLEAR -> CLEAR lasts 16 more cycles, counted from the restart.
REQ-042 DEPTH=12, INDEX=4; write addr 13 -> dropped, and reading addr 13 returns 0; CLEAR lasts 12 cycles.

Source files
------------

// File: rtl/ldvio_mp_ram_pkg.sv
// ldvio_mp_ram_pkg
//   Shared definitions for the multi-port RAM:
//   - state_t      : controller state (CLEAR while storage is being zeroed, READY otherwise)
//   - MAX_RD_PORTS : upper bound on read port count
//   - MAX_WR_PORTS : upper bound on write port count
package ldvio_mp_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int MAX_RD_PORTS = 8;
    localparam int MAX_WR_PORTS = 4;

endpackage

// File: rtl/ldvio_wr_merge.sv
// ldvio_wr_merge
//   Resolves which write port owns a given address this cycle. Among all
//   enabled write ports whose address equals match_addr, the highest port
//   index wins.
//   Ports:
//     match_addr : address being looked up
//     we         : per-port write enable (already qualified by the caller)
//     wr_addr    : per-port write address
//     wr_data    : per-port write data
//     hit        : at least one enabled port writes match_addr
//     data       : winning write data (0 when no hit)
module ldvio_wr_merge #(
    parameter int INDEX    = 4,
    parameter int WIDTH    = 8,
    parameter int WR_PORTS = 2
) (
    input  logic [INDEX-1:0]                 match_addr,
    input  logic [WR_PORTS-1:0]              we,
    input  logic [WR_PORTS-1:0][INDEX-1:0]   wr_addr,
    input  logic [WR_PORTS-1:0][WIDTH-1:0]   wr_data,
    output logic                             hit,
    output logic [WIDTH-1:0]                 data
);

    logic [WR_PORTS-1:0] match;

    generate
        for (genvar gi = 0; gi < WR_PORTS; gi++) begin : g_match
            assign match[gi] = we[gi] && (wr_addr[gi] == match_addr);
        end
    endgenerate

    // Ascending scan: a later (higher-index) match overrides earlier ones.
    always_comb begin
        data = '0;
        for (int w = 0; w < WR_PORTS; w++) begin
            if (match[w]) begin
                data = wr_data[w];
            end
        end
    end

    assign hit = |match;

endmodule

// File: rtl/ldvio_mp_ram.sv
// ldvio_mp_ram
//   Multi-port register RAM with combinational reads, optional write-to-read
//   forwarding, and a self-clearing sequence (one entry per cycle) after reset
//   or flush. Writes are accepted only while ready_o is high.
//   Ports:
//     clk        : clock, rising edge
//     reset      : synchronous active-high reset; restarts the clear sequence
//     flush_i    : restart the clear sequence
//     rd_addr_i  : RD_PORTS read addresses
//     rd_data_o  : RD_PORTS read data (0 while clearing or out of range)
//     wr_addr_i  : WR_PORTS write addresses
//     wr_data_i  : WR_PORTS write data
//     we_i       : per-port write enable
//     ready_o    : storage initialised, writes accepted
module ldvio_mp_ram
    import ldvio_mp_ram_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int INDEX    = 4,
    parameter int WIDTH    = 8,
    parameter int RD_PORTS = 4,
    parameter int WR_PORTS = 2,
    parameter int BYPASS   = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush_i,
    input  logic [RD_PORTS-1:0][INDEX-1:0]   rd_addr_i,
    output logic [RD_PORTS-1:0][WIDTH-1:0]   rd_data_o,
    input  logic [WR_PORTS-1:0][INDEX-1:0]   wr_addr_i,
    input  logic [WR_PORTS-1:0][WIDTH-1:0]   wr_data_i,
    input  logic [WR_PORTS-1:0]              we_i,
    output logic                             ready_o
);

    // One extra bit so DEPTH == 2**INDEX is representable in the range check.
    localparam logic [INDEX:0]   DEPTH_W   = (INDEX+1)'(DEPTH);
    localparam logic [INDEX-1:0] LAST_ADDR = INDEX'(DEPTH - 1);

    state_t           state_reg;
    logic [INDEX-1:0] clr_ptr_reg;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [WR_PORTS-1:0]            wr_req;
    logic [WR_PORTS-1:0]            wr_hit;
    logic [WR_PORTS-1:0][WIDTH-1:0] wr_merged;
    logic [WR_PORTS-1:0]            wr_commit;

    // ------------------------------------------------------------------
    // Controller: CLEAR walks clr_ptr from 0 to DEPTH-1, then READY.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= CLEAR;
            clr_ptr_reg <= '0;
        end else begin
            case (state_reg)
                CLEAR: begin
                    if (flush_i) begin
                        clr_ptr_reg <= '0;
                    end else if (clr_ptr_reg == LAST_ADDR) begin
                        state_reg   <= READY;
                        clr_ptr_reg <= '0;
                    end else begin
                        clr_ptr_reg <= clr_ptr_reg + 1'b1;
                    end
                end
                READY: begin
                    if (flush_i) begin
                        state_reg   <= CLEAR;
                        clr_ptr_reg <= '0;
                    end
                end
                default: begin
                    state_reg   <= CLEAR;
                    clr_ptr_reg <= '0;
                end
            endcase
        end
    end

    assign ready_o = (state_reg == READY);

    // ------------------------------------------------------------------
    // Write path. A write is live only in READY, with no reset or flush
    // this cycle, and with an in-range address. Each write port looks up
    // the winning data for its own address, so ports colliding on one
    // entry all store the same (highest-port) value and order is moot.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < WR_PORTS; gi++) begin : g_wr
            assign wr_req[gi] = we_i[gi] && ready_o && !reset && !flush_i
                                && ({1'b0, wr_addr_i[gi]} < DEPTH_W);

            ldvio_wr_merge #(
                .INDEX    (INDEX),
                .WIDTH    (WIDTH),
                .WR_PORTS (WR_PORTS)
            ) u_wr_merge (
                .match_addr (wr_addr_i[gi]),
                .we         (wr_req),
                .wr_addr    (wr_addr_i),
                .wr_data    (wr_data_i),
                .hit        (wr_hit[gi]),
                .data       (wr_merged[gi])
            );

            assign wr_commit[gi] = wr_req[gi] && wr_hit[gi];
        end
    endgenerate

    // Storage has no reset: it is zeroed only by the CLEAR walk.
    always_ff @(posedge clk) begin
        if (state_reg == CLEAR) begin
            mem[clr_ptr_reg] <= '0;
        end else begin
            for (int w = 0; w < WR_PORTS; w++) begin
                if (wr_commit[w]) begin
                    mem[wr_addr_i[w]] <= wr_merged[w];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path: combinational, zero while clearing or out of range.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < RD_PORTS; gi++) begin : g_rd
            logic             rd_in_range;
            logic             fwd_hit;
            logic [WIDTH-1:0] fwd_data;

            assign rd_in_range = ({1'b0, rd_addr_i[gi]} < DEPTH_W);

            ldvio_wr_merge #(
                .INDEX    (INDEX),
                .WIDTH    (WIDTH),
                .WR_PORTS (WR_PORTS)
            ) u_fwd_merge (
                .match_addr (rd_addr_i[gi]),
                .we         (wr_req),
                .wr_addr    (wr_addr_i),
                .wr_data    (wr_data_i),
                .hit        (fwd_hit),
                .data       (fwd_data)
            );

            assign rd_data_o[gi] = (!ready_o || !rd_in_range) ? '0 :
                                   ((BYPASS != 0) && fwd_hit) ? fwd_data :
                                   mem[rd_addr_i[gi]];
        end
    endgenerate

endmodule

// File: tb/tb_ldvio_mp_ram.sv
// tb_ldvio_mp_ram
//   Directed bench for ldvio_mp_ram. Three instances share the stimulus:
//   u_byp (defaults, BYPASS=1), u_nob (BYPASS=0) and u_d12 (DEPTH=12).
module tb_ldvio_mp_ram;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 flush;
    logic [3:0][3:0]      rd_addr;
    logic [1:0][3:0]      wr_addr;
    logic [1:0][7:0]      wr_data;
    logic [1:0]           we;
    logic [3:0][7:0]      rd_b, rd_n, rd_12;
    logic                 rdy_b, rdy_n, rdy_12;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ldvio_mp_ram #(.BYPASS(1)) u_byp (
        .clk(clk), .reset(reset), .flush_i(flush),
        .rd_addr_i(rd_addr), .rd_data_o(rd_b),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data), .we_i(we),
        .ready_o(rdy_b)
    );

    ldvio_mp_ram #(.BYPASS(0)) u_nob (
        .clk(clk), .reset(reset), .flush_i(flush),
        .rd_addr_i(rd_addr), .rd_data_o(rd_n),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data), .we_i(we),
        .ready_o(rdy_n)
    );

    ldvio_mp_ram #(.DEPTH(12), .INDEX(4)) u_d12 (
        .clk(clk), .reset(reset), .flush_i(flush),
        .rd_addr_i(rd_addr), .rd_data_o(rd_12),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data), .we_i(we),
        .ready_o(rdy_12)
    );

    typedef struct packed {
        logic [1:0]      we;
        logic [1:0][3:0] wa;
        logic [1:0][7:0] wd;
        logic [3:0][3:0] ra;
        logic [3:0][7:0] eb;   // expected with forwarding
        logic [3:0][7:0] en;   // expected without forwarding
    } vec_t;

    vec_t vecs [9];

    // ra/eb/en are packed with port 0 in the least significant field.
    function automatic vec_t mk(logic [1:0] w, logic [3:0] a0, logic [7:0] d0,
                                logic [3:0] a1, logic [7:0] d1, logic [15:0] ra,
                                logic [31:0] eb, logic [31:0] en);
        vec_t v;
        v.we    = w;
        v.wa[0] = a0;
        v.wd[0] = d0;
        v.wa[1] = a1;
        v.wd[1] = d1;
        v.ra    = ra;
        v.eb    = eb;
        v.en    = en;
        return v;
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_rd(logic [3:0] a);
        for (int p = 0; p < 4; p++) rd_addr[p] = a;
    endtask

    task automatic check_all_zero(string name);
        for (int a = 0; a < 16; a++) begin
            set_rd(4'(a));
            #1;
            for (int p = 0; p < 4; p++) begin
                chk($sformatf("%s_byp_a%0d_p%0d", name, a, p), rd_b[p], 8'h00);
                chk($sformatf("%s_nob_a%0d_p%0d", name, a, p), rd_n[p], 8'h00);
            end
        end
    endtask

    initial begin
        vecs[0] = mk(2'b11, 4'd3,  8'hA5, 4'd3,  8'h5A, 16'h3333, 32'h5A5A5A5A, 32'h00000000);
        vecs[1] = mk(2'b00, 4'd0,  8'h00, 4'd0,  8'h00, 16'h3333, 32'h5A5A5A5A, 32'h5A5A5A5A);
        vecs[2] = mk(2'b01, 4'd7,  8'h11, 4'd0,  8'h00, 16'h7703, 32'h1111005A, 32'h0000005A);
        vecs[3] = mk(2'b00, 4'd0,  8'h00, 4'd0,  8'h00, 16'h0377, 32'h005A1111, 32'h005A1111);
        vecs[4] = mk(2'b11, 4'd2,  8'hC3, 4'd9,  8'h3C, 16'h1792, 32'h00113CC3, 32'h00110000);
        vecs[5] = mk(2'b10, 4'd2,  8'hFF, 4'd2,  8'h77, 16'h2922, 32'h773C7777, 32'hC33CC3C3);
        vecs[6] = mk(2'b00, 4'd0,  8'h00, 4'd0,  8'h00, 16'h7392, 32'h115A3C77, 32'h115A3C77);
        vecs[7] = mk(2'b11, 4'd15, 8'hEE, 4'd15, 8'hDD, 16'h2FEF, 32'h77DD00DD, 32'h77000000);
        vecs[8] = mk(2'b00, 4'd0,  8'h00, 4'd0,  8'h00, 16'hFFFF, 32'hDDDDDDDD, 32'hDDDDDDDD);

        reset   = 1'b1;
        flush   = 1'b0;
        we      = '0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;

        // Reset, then the initial clear walk.
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", {7'd0, rdy_b}, 8'd0);
        chk("rst_rd0",   rd_b[0], 8'h00);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            set_rd(4'(i));
            #1;
            chk($sformatf("clr_ready_c%0d", i),     {7'd0, rdy_b},  8'd0);
            chk($sformatf("clr_rd_c%0d", i),        rd_b[0],        8'h00);
            chk($sformatf("clr_d12_ready_c%0d", i), {7'd0, rdy_12}, {7'd0, (i >= 12)});
            cyc();
        end
        #1;
        chk("clr_done_byp", {7'd0, rdy_b}, 8'd1);
        chk("clr_done_nob", {7'd0, rdy_n}, 8'd1);
        check_all_zero("init");

        // Table-driven READY traffic.
        for (int v = 0; v < 9; v++) begin
            we         = vecs[v].we;
            wr_addr    = vecs[v].wa;
            wr_data    = vecs[v].wd;
            rd_addr    = vecs[v].ra;
            #1;
            for (int p = 0; p < 4; p++) begin
                chk($sformatf("vec%0d_byp_p%0d", v, p), rd_b[p], vecs[v].eb[p]);
                chk($sformatf("vec%0d_nob_p%0d", v, p), rd_n[p], vecs[v].en[p]);
            end
            cyc();
        end
        we = '0;

        // Flush in READY beats a same-cycle write (also not forwarded).
        flush      = 1'b1;
        we         = 2'b01;
        wr_addr[0] = 4'd5;
        wr_data[0] = 8'h99;
        rd_addr[0] = 4'd5;
        #1;
        chk("flush_fwd_dropped", rd_b[0], 8'h00);
        cyc();
        flush   = 1'b0;
        we      = 2'b11;
        wr_addr = {4'd3, 4'd3};
        wr_data = {8'hFF, 8'hFF};
        set_rd(4'd3);
        for (int i = 0; i < 16; i++) begin
            #1;
            chk($sformatf("flush_ready_c%0d", i), {7'd0, rdy_b}, 8'd0);
            chk($sformatf("flush_rd_c%0d", i),    rd_b[1],       8'h00);
            cyc();
        end
        we = '0;
        #1;
        chk("flush_done", {7'd0, rdy_b}, 8'd1);
        check_all_zero("post_flush");

        // Flush again while clearing at clr_ptr=9: walk restarts from 0.
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        for (int i = 0; i < 9; i++) cyc();
        #1;
        chk("mid_clear_ready", {7'd0, rdy_b}, 8'd0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk($sformatf("restart_ready_c%0d", i), {7'd0, rdy_b}, 8'd0);
            cyc();
        end
        #1;
        chk("restart_done_byp", {7'd0, rdy_b}, 8'd1);
        chk("restart_done_nob", {7'd0, rdy_n}, 8'd1);

        // Reset from READY beats a same-cycle write.
        reset      = 1'b1;
        we         = 2'b01;
        wr_addr[0] = 4'd1;
        wr_data[0] = 8'h33;
        cyc();
        reset = 1'b0;
        we    = '0;
        #1;
        chk("rst_from_ready", {7'd0, rdy_b}, 8'd0);
        for (int i = 0; i < 12; i++) begin
            #1;
            chk($sformatf("d12_ready_c%0d", i), {7'd0, rdy_12}, 8'd0);
            cyc();
        end
        #1;
        chk("d12_done",         {7'd0, rdy_12}, 8'd1);
        chk("d16_still_clear",  {7'd0, rdy_b},  8'd0);
        for (int i = 0; i < 4; i++) cyc();
        #1;
        chk("d16_done", {7'd0, rdy_b}, 8'd1);
        set_rd(4'd1);
        #1;
        chk("rst_write_dropped", rd_b[0], 8'h00);

        // DEPTH=12: address 13 is out of range, address 4 is not.
        we         = 2'b11;
        wr_addr    = {4'd4, 4'd13};
        wr_data    = {8'h24, 8'h42};
        rd_addr    = {4'd11, 4'd13, 4'd4, 4'd13};
        #1;
        chk("d12_fwd_p0_a13", rd_12[0], 8'h00);
        chk("d12_fwd_p1_a4",  rd_12[1], 8'h24);
        chk("d12_fwd_p2_a13", rd_12[2], 8'h00);
        chk("d12_fwd_p3_a11", rd_12[3], 8'h00);
        chk("d16_fwd_a13",    rd_b[0],  8'h42);
        cyc();
        we = '0;
        #1;
        chk("d12_rd_p0_a13", rd_12[0], 8'h00);
        chk("d12_rd_p1_a4",  rd_12[1], 8'h24);
        chk("d12_rd_p2_a13", rd_12[2], 8'h00);
        chk("d12_rd_p3_a11", rd_12[3], 8'h00);
        chk("d16_rd_a13",    rd_b[0],  8'h42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
